// File: rtl/intt_stage_sequencer_if.sv
// Host/datapath bundle for the INTT/NTT stage sequencer: pass handshake in,
// per-stage addressing, twiddle indices and bank selects out.
interface intt_stage_sequencer_if #(
  parameter int AW = 6,
  parameter int SW = 4
);
  logic          start;
  logic          direction;
  logic          abort;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic [SW-1:0] log_m;
  logic [SW-1:0] log_t;
  logic [1:0]    mode;
  logic          read_valid;
  logic [AW-1:0] upper_read_address;
  logic [AW-1:0] lower_read_address;
  logic [AW-1:0] group_index;
  logic          input_select;
  logic          read_select;
  logic          write_enable;
  logic          write_select;

  modport master (
    output start, direction, abort,
    input  busy, done, stage, log_m, log_t, mode, read_valid,
           upper_read_address, lower_read_address, group_index,
           input_select, read_select, write_enable, write_select
  );

  modport slave (
    input  start, direction, abort,
    output busy, done, stage, log_m, log_t, mode, read_valid,
           upper_read_address, lower_read_address, group_index,
           input_select, read_select, write_enable, write_select
  );
endinterface

// File: rtl/intt_stage_sequencer.sv
// Sequences a full LOG_N-stage INTT/NTT pass over 2^LOG_CORE_COUNT butterfly
// cores: read addresses, twiddle group index, bank ping-pong and write strobes.
module intt_stage_sequencer #(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 4,
  parameter int WRITE_LATENCY  = 10,
  parameter int STAGE_GAP      = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  intt_stage_sequencer_if.slave bus
);
  localparam int AW   = LOG_N - 2 - LOG_CORE_COUNT;
  localparam int SW   = $clog2(LOG_N + 1);
  localparam int TMAX = (STAGE_GAP > WRITE_LATENCY) ? STAGE_GAP : WRITE_LATENCY;
  localparam int TW   = $clog2(TMAX + 2);

  localparam logic [AW-1:0] CNT_LAST   = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG_N - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(WRITE_LATENCY - 1);

  localparam logic [1:0] MODE_FIRST   = 2'd0;
  localparam logic [1:0] MODE_SECOND  = 2'd1;
  localparam logic [1:0] MODE_THIRD   = 2'd2;
  localparam logic [1:0] MODE_STANDBY = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          dir_q, dir_d;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic          done_d;

  logic          busy_nx, rv_nx, isel_nx, rsel_nx;
  logic [SW-1:0] lt_nx, lm_nx;
  logic [1:0]    mode_nx;
  logic [AW-1:0] addr_nx, gidx_nx;
  logic          wsel_iss;

  function automatic logic [SW-1:0] stage_exp(input logic dir, input logic [SW-1:0] s);
    return dir ? (STAGE_LAST - s) : s;
  endfunction

  function automatic logic [1:0] stage_mode(input logic [SW-1:0] s);
    if (s == '0) return MODE_FIRST;
    if (int'(s) <= AW) return MODE_SECOND;
    return MODE_THIRD;
  endfunction

  function automatic logic [AW-1:0] group_idx(input logic [AW-1:0] c, input logic [SW-1:0] lt);
    return (int'(lt) < AW) ? (c >> lt) : '0;
  endfunction

  // state and registered outputs (outputs are the decode of next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      stage_q                <= '0;
      tmr_q                  <= '0;
      dir_q                  <= 1'b0;
      wsel_q                 <= 1'b0;
      rsel_q                 <= 1'b0;
      bus.busy               <= 1'b0;
      bus.done               <= 1'b0;
      bus.stage              <= '0;
      bus.log_m              <= '0;
      bus.log_t              <= '0;
      bus.mode               <= MODE_STANDBY;
      bus.read_valid         <= 1'b0;
      bus.upper_read_address <= '0;
      bus.lower_read_address <= '0;
      bus.group_index        <= '0;
      bus.input_select       <= 1'b0;
      bus.read_select        <= 1'b0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      stage_q                <= stage_d;
      tmr_q                  <= tmr_d;
      dir_q                  <= dir_d;
      wsel_q                 <= wsel_d;
      rsel_q                 <= rsel_d;
      bus.busy               <= busy_nx;
      bus.done               <= done_d;
      bus.stage              <= stage_d;
      bus.log_m              <= lm_nx;
      bus.log_t              <= lt_nx;
      bus.mode               <= mode_nx;
      bus.read_valid         <= rv_nx;
      bus.upper_read_address <= addr_nx;
      bus.lower_read_address <= addr_nx;
      bus.group_index        <= gidx_nx;
      bus.input_select       <= isel_nx;
      bus.read_select        <= rsel_nx;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    tmr_d   = tmr_q;
    dir_d   = dir_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          stage_d = '0;
          dir_d   = bus.direction;
          wsel_d  = 1'b0;
          rsel_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          wsel_d = ~wsel_q;
          tmr_d  = '0;
          cnt_d  = '0;
          if (stage_q == STAGE_LAST) begin
            if (WRITE_LATENCY == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
              stage_d = '0;
            end else begin
              state_d = DRAIN;
            end
          end else if (STAGE_GAP == 0) begin
            stage_d = stage_q + 1'b1;
            rsel_d  = ~rsel_q;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = RUN;
          stage_d = stage_q + 1'b1;
          rsel_d  = ~rsel_q;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (tmr_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          stage_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort dominates everything, including a simultaneous start
    if (bus.abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      cnt_d   = '0;
      stage_d = '0;
      tmr_d   = '0;
    end
  end

  always_comb begin
    busy_nx = (state_d != IDLE);
    rv_nx   = (state_d == RUN);
    lt_nx   = busy_nx ? stage_exp(dir_d, stage_d) : '0;
    lm_nx   = busy_nx ? (SW'(LOG_N) - lt_nx) : '0;
    mode_nx = busy_nx ? stage_mode(stage_d) : MODE_STANDBY;
    addr_nx = rv_nx ? cnt_d : '0;
    gidx_nx = rv_nx ? group_idx(cnt_d, lt_nx) : '0;
    isel_nx = rv_nx && (stage_d == '0);
    rsel_nx = busy_nx && rsel_d;
  end

  assign wsel_iss = bus.busy & wsel_q;

  // write pipe: each read carries its own bank select to write-back
  generate
    if (WRITE_LATENCY == 0) begin : g_no_pipe
      assign bus.write_enable = bus.read_valid;
      assign bus.write_select = wsel_iss;
    end else begin : g_pipe
      logic [WRITE_LATENCY-1:0] wr_vld_p;
      logic [WRITE_LATENCY-1:0] wr_sel_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_vld_p <= '0;
          wr_sel_p <= '0;
        end else if (bus.abort) begin
          wr_vld_p <= '0;
          wr_sel_p <= '0;
        end else begin
          wr_vld_p[0] <= bus.read_valid;
          wr_sel_p[0] <= wsel_iss;
          for (int i = 1; i < WRITE_LATENCY; i++) begin
            wr_vld_p[i] <= wr_vld_p[i-1];
            wr_sel_p[i] <= wr_sel_p[i-1];
          end
        end
      end
      assign bus.write_enable = wr_vld_p[WRITE_LATENCY-1];
      assign bus.write_select = wr_sel_p[WRITE_LATENCY-1];
    end
  endgenerate
endmodule

// File: tb/tb_intt_stage_sequencer.sv
// Bench for intt_stage_sequencer: default config on a queue scoreboard plus a
// small LOG_N=8 instance checked on pass length and strobe counts.
`timescale 1ns/1ps
module tb_intt_stage_sequencer;
  localparam int LOG_N = 12;
  localparam int LCC   = 4;
  localparam int WL    = 10;
  localparam int GAP   = 10;
  localparam int AW    = LOG_N - 2 - LCC;
  localparam int SW    = $clog2(LOG_N + 1);
  localparam int C     = 1 << AW;
  localparam int SNW   = 9 + 3 * SW + 3 * AW;
  localparam logic [SNW-1:0] IDLE_SNAP = SNW'(3) << (3 * SW + 3 * AW);

  typedef struct packed {
    int            cyc;
    logic [SW-1:0] stage;
    logic [SW-1:0] log_m;
    logic [SW-1:0] log_t;
    logic [1:0]    mode;
    logic [AW-1:0] ua;
    logic [AW-1:0] la;
    logic [AW-1:0] gi;
    logic          isel;
    logic          rsel;
  } rd_t;

  typedef struct packed {
    int   cyc;
    logic wsel;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   rd2 = 0;
  int   wr2 = 0;

  rd_t rdq[$];
  wr_t wrq[$];
  int  doneq[$];
  int  done2q[$];

  intt_stage_sequencer_if #(.AW(AW), .SW(SW)) bus ();
  intt_stage_sequencer_if #(.AW(4), .SW(4))   bus2 ();

  intt_stage_sequencer #(
    .LOG_N(LOG_N), .LOG_CORE_COUNT(LCC), .WRITE_LATENCY(WL), .STAGE_GAP(GAP)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  intt_stage_sequencer #(
    .LOG_N(8), .LOG_CORE_COUNT(2), .WRITE_LATENCY(3), .STAGE_GAP(3)
  ) dut_small (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s @cycle %0d: strobe seen, required none", name, cyc);
  endtask

  function automatic logic [SNW-1:0] snap();
    return {bus.busy, bus.done, bus.read_valid, bus.write_enable, bus.write_select,
            bus.read_select, bus.input_select, bus.mode, bus.stage, bus.log_m, bus.log_t,
            bus.upper_read_address, bus.lower_read_address, bus.group_index};
  endfunction

  task automatic push_pass(input int ts, input logic dir, input int done_at);
    int  k;
    int  e;
    rd_t r;
    wr_t w;
    k = ts + 1;
    for (int s = 0; s < LOG_N; s++) begin
      e = dir ? (LOG_N - 1 - s) : s;
      for (int c = 0; c < C; c++) begin
        r.cyc   = k;
        r.stage = SW'(s);
        r.log_t = SW'(e);
        r.log_m = SW'(LOG_N - e);
        r.mode  = (s == 0) ? 2'd0 : ((s <= AW) ? 2'd1 : 2'd2);
        r.ua    = AW'(c);
        r.la    = AW'(c);
        r.gi    = (e < AW) ? AW'(c >> e) : '0;
        r.isel  = (s == 0);
        r.rsel  = (s % 2 == 1);
        rdq.push_back(r);
        w.cyc  = k + WL;
        w.wsel = (s % 2 == 1);
        wrq.push_back(w);
        k++;
      end
      k += GAP;
    end
    doneq.push_back(done_at);
  endtask

  task automatic flush_from(input int c);
    while (rdq.size() > 0 && rdq[$].cyc >= c) void'(rdq.pop_back());
    while (wrq.size() > 0 && wrq[$].cyc >= c) void'(wrq.pop_back());
    while (doneq.size() > 0 && doneq[$] >= c) void'(doneq.pop_back());
  endtask

  task automatic drained(input string name);
    check(name, 128'({rdq.size(), wrq.size(), doneq.size(), done2q.size()}), 128'(0));
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: default-config DUT against the scoreboard queues
  always @(negedge clk) begin
    rd_t a;
    rd_t x;
    wr_t wa;
    wr_t wx;
    if (rst_n) begin
      if (bus.read_valid) begin
        a.cyc = cyc; a.stage = bus.stage; a.log_m = bus.log_m; a.log_t = bus.log_t;
        a.mode = bus.mode; a.ua = bus.upper_read_address; a.la = bus.lower_read_address;
        a.gi = bus.group_index; a.isel = bus.input_select; a.rsel = bus.read_select;
        if (rdq.size() == 0) unexpected("read_valid");
        else begin
          x = rdq.pop_front();
          check("read", 128'(a), 128'(x));
        end
      end
      if (bus.write_enable) begin
        wa.cyc = cyc; wa.wsel = bus.write_select;
        if (wrq.size() == 0) unexpected("write_enable");
        else begin
          wx = wrq.pop_front();
          check("write", 128'(wa), 128'(wx));
        end
      end
      if (bus.done) begin
        if (doneq.size() == 0) unexpected("done");
        else check("done_cycle_busy", 128'({cyc, bus.busy}), 128'({doneq.pop_front(), 1'b0}));
      end
    end
  end

  // monitor: small configuration, pass length and strobe totals
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus2.done) begin
        if (done2q.size() == 0) unexpected("small_done");
        else check("small_done", 128'({cyc, rd2, wr2, 31'd0, bus2.busy}),
                   128'({done2q.pop_front(), 32'd128, 32'd128, 32'd0}));
        rd2 = 0;
        wr2 = 0;
      end else begin
        if (bus2.read_valid) rd2++;
        if (bus2.write_enable) wr2++;
      end
    end
  end

  initial begin
    int t0;
    bus.start = 1'b0; bus.direction = 1'b0; bus.abort = 1'b0;
    bus2.start = 1'b0; bus2.direction = 1'b0; bus2.abort = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", 128'(snap()), 128'(IDLE_SNAP));
    goto(3);
    rst_n = 1'b1;
    goto(8);
    check("idle_not_running", 128'(snap()), 128'(IDLE_SNAP));

    // INTT pass on both instances, with a stray start mid-pass
    t0 = cyc;
    bus.start = 1'b1; bus.direction = 1'b0;
    bus2.start = 1'b1; bus2.direction = 1'b0;
    push_pass(t0, 1'b0, t0 + 889);
    done2q.push_back(t0 + 153);
    check("busy_cycle0", 128'(bus.busy), 128'(1'b0));
    goto(t0 + 1);
    bus.start = 1'b0; bus2.start = 1'b0;
    check("busy_cycle1", 128'({bus.busy, bus.read_valid, bus.input_select, bus2.busy}), 128'(4'b1111));
    goto(t0 + 100);
    bus.start = 1'b1; bus.direction = 1'b1;
    goto(t0 + 101);
    bus.start = 1'b0; bus.direction = 1'b0;
    goto(t0 + 154);
    check("stage2_c5", 128'({bus.stage, bus.log_t, bus.upper_read_address, bus.group_index}),
          128'({4'd2, 4'd2, 6'd5, 6'd1}));
    goto(t0 + 582);
    check("stage7_c63", 128'({bus.stage, bus.mode, bus.upper_read_address, bus.group_index}),
          128'({4'd7, 2'd2, 6'd63, 6'd0}));
    goto(t0 + 895);
    check("idle_after_intt", 128'(snap()), 128'(IDLE_SNAP));
    drained("drained_intt");

    // NTT pass; direction dropped right after start must stay latched
    t0 = cyc;
    bus.start = 1'b1; bus.direction = 1'b1;
    push_pass(t0, 1'b1, t0 + 889);
    goto(t0 + 1);
    bus.start = 1'b0; bus.direction = 1'b0;
    check("ntt_stage0", 128'({bus.log_t, bus.log_m, bus.mode}), 128'({4'd11, 4'd1, 2'd0}));
    goto(t0 + 895);
    drained("drained_ntt");

    // abort at cycle 300, restart at 305
    t0 = cyc;
    bus.start = 1'b1;
    push_pass(t0, 1'b0, t0 + 889);
    goto(t0 + 1);
    bus.start = 1'b0;
    goto(t0 + 300);
    bus.abort = 1'b1;
    flush_from(t0 + 301);
    goto(t0 + 301);
    bus.abort = 1'b0;
    check("after_abort", 128'({bus.busy, bus.done, bus.read_valid, bus.write_enable, bus.mode}),
          128'({4'b0000, 2'b11}));
    goto(t0 + 305);
    bus.start = 1'b1;
    push_pass(t0 + 305, 1'b0, t0 + 305 + 889);
    goto(t0 + 306);
    bus.start = 1'b0;
    goto(t0 + 305 + 895);
    drained("drained_abort_replay");

    // abort together with start in IDLE
    t0 = cyc;
    bus.start = 1'b1; bus.abort = 1'b1;
    goto(t0 + 1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_beats_start", 128'({bus.busy, bus.read_valid}), 128'(2'b00));
    goto(t0 + 20);

    // asynchronous reset mid-pass
    t0 = cyc;
    bus.start = 1'b1;
    push_pass(t0, 1'b0, t0 + 889);
    goto(t0 + 1);
    bus.start = 1'b0;
    goto(t0 + 500);
    rst_n = 1'b0;
    flush_from(t0 + 500);
    #1;
    check("async_reset_midpass", 128'(snap()), 128'(IDLE_SNAP));
    goto(t0 + 503);
    rst_n = 1'b1;
    goto(t0 + 510);
    check("idle_after_reset", 128'(snap()), 128'(IDLE_SNAP));
    goto(t0 + 900);
    drained("drained_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
